voice_sequencer: RTL and testbench

Step sequencer that drives one `voice` instance's control inputs (`tone_freq`, `waveform_enable`, `gate`) from a small writable pattern memory. It is the initiator side of the voice control interface. It runs on the main clock, advances one step every programmable number of cycles, and asserts `gate` for a programmable fraction of each step so the voice's envelope runs attack/decay/sustain followed by release. It sits between the host register interface and each `voice`, one sequencer per voice.

---
 rtl/voice_seq_pkg.sv | 31 +++
 rtl/voice_seq_timer.sv | 96 +++++++++
 rtl/voice_sequencer.sv | 128 ++++++++++++
 tb/tb_voice_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_seq_pkg.sv
// -----------------------------------------------------------------------------
// voice_seq_pkg
// Shared definitions for the voice step sequencer:
//   - FSM state encoding (IDLE, LOAD, GATE_ON, GATE_OFF)
//   - step-entry field layout. An entry is {note_on, gate_len, waveform, freq}
//     with freq in the low FREQ_BITS; the control fields sit above freq at the
//     offsets below.
//   - minimum step period
// -----------------------------------------------------------------------------
package voice_seq_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_LOAD     = 2'd1;
  localparam logic [1:0] ST_GATE_ON  = 2'd2;
  localparam logic [1:0] ST_GATE_OFF = 2'd3;

  // Control field widths.
  localparam int unsigned WAVE_W    = 4;
  localparam int unsigned GLEN_W    = 4;
  localparam int unsigned NOTE_W    = 1;
  localparam int unsigned CTRL_BITS = WAVE_W + GLEN_W + NOTE_W;

  // Control field offsets, counted from the bit just above freq.
  localparam int unsigned WAVE_OFS = 0;
  localparam int unsigned GLEN_OFS = WAVE_OFS + WAVE_W;
  localparam int unsigned NOTE_OFS = GLEN_OFS + GLEN_W;

  // Shortest step length in clk cycles; smaller step_period values clamp here.
  localparam int unsigned MIN_PERIOD = 4;

endpackage

// File: rtl/voice_seq_timer.sv
// -----------------------------------------------------------------------------
// voice_seq_timer
// Step timing for voice_sequencer. Owns the cycle counter, the period clamp,
// the gate-length computation and (optionally) swing.
//
// Ports:
//   clk, rst        main clock, synchronous active-low reset
//   load            step load: restart the count and capture length/gate
//   active          count while a step is playing
//   step_period     requested cycles per step (clamped to MIN_PERIOD)
//   gate_len        gate_len field of the entry being loaded
//   odd_step        parity of the step being loaded (swing builds only)
//   swing           swing amount (swing builds only)
//   step_end        current cycle is the last of the step
//   gate_end        current cycle is the last gated cycle of a shortened gate
//
// Build option: VOICE_SEQ_SWING_EN adds odd_step/swing; even steps last
// P+swing, odd steps P-swing, swing clamped to P/2-1.
// -----------------------------------------------------------------------------
module voice_seq_timer
  import voice_seq_pkg::*;
#(
  parameter int TEMPO_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  active,
  input  logic [TEMPO_BITS-1:0] step_period,
  input  logic [GLEN_W-1:0]     gate_len,
`ifdef VOICE_SEQ_SWING_EN
  input  logic                  odd_step,
  input  logic [TEMPO_BITS-3:0] swing,
`endif
  output logic                  step_end,
  output logic                  gate_end
);

`ifdef VOICE_SEQ_SWING_EN
  // P + swing can exceed the period range, so lengths carry one extra bit.
  localparam int LEN_BITS = TEMPO_BITS + 1;
  logic [TEMPO_BITS-1:0] swing_max;
  logic [TEMPO_BITS-1:0] swing_c;
`else
  localparam int LEN_BITS = TEMPO_BITS;
`endif

  logic [TEMPO_BITS-1:0] period;
  logic [LEN_BITS-1:0]   len;
  logic [LEN_BITS+4:0]   gate_prod;
  logic [LEN_BITS-1:0]   gate_new;
  logic [LEN_BITS-1:0]   cyc_cnt;
  logic [LEN_BITS-1:0]   len_q;
  logic [LEN_BITS-1:0]   gate_q;

  // NOTE: every signal driven here is fully assigned on every path, so no
  // latch is inferred.
  always_comb begin
    period = (step_period < TEMPO_BITS'(MIN_PERIOD)) ? TEMPO_BITS'(MIN_PERIOD)
                                                      : step_period;
`ifdef VOICE_SEQ_SWING_EN
    swing_max = (period >> 1) - 1'b1;
    swing_c   = ({2'b00, swing} > swing_max) ? swing_max : {2'b00, swing};
    len       = odd_step ? ({1'b0, period} - {1'b0, swing_c})
                         : ({1'b0, period} + {1'b0, swing_c});
`else
    len       = period;
`endif
    // G = (len * (gate_len+1)) >> 4; gate_len+1 <= 16 keeps G <= len.
    gate_prod = {5'd0, len} * {{LEN_BITS{1'b0}}, ({1'b0, gate_len} + 5'd1)};
    gate_new  = LEN_BITS'(gate_prod >> 4);
  end

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cyc_cnt <= '0;
      len_q   <= LEN_BITS'(MIN_PERIOD);
      gate_q  <= '0;
    end else if (load) begin
      cyc_cnt <= '0;
      len_q   <= len;
      gate_q  <= gate_new;
    end else if (active) begin
      cyc_cnt <= cyc_cnt + 1'b1;
    end
  end

  assign step_end = (cyc_cnt == len_q - 1'b1);
  // Fires at cycle G-1; a zero G still yields a one-cycle gate. Full-length
  // gates (G == len) never drop inside the step, giving legato.
  assign gate_end = (gate_q < len_q) &&
                    (({1'b0, cyc_cnt} + 1'b1) >= {1'b0, gate_q});

endmodule

// File: rtl/voice_sequencer.sv
// -----------------------------------------------------------------------------
// voice_sequencer
// Step sequencer driving one voice's tone_freq / waveform_enable / gate from a
// writable pattern memory. One step advances every P = max(step_period, 4)
// cycles; gate is held for G = (P*(gate_len+1))>>4 cycles of a note_on step.
//
// Ports:
//   clk, rst               main clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data  pattern write port; entry = {note_on, gate_len,
//                          waveform, freq}
//   run                    level, high = play; each rise restarts at step 0
//   step_period            cycles per step (clamped to 4)
//   loop_last              last step index before wrapping to 0
//   swing                  swing amount (VOICE_SEQ_SWING_EN builds only)
//   tone_freq, waveform_enable, gate   voice control outputs (registered)
//   step_idx               step currently playing
//   step_strobe            one-cycle pulse on every step load
//
// Build option: VOICE_SEQ_SWING_EN enables swing timing.
// -----------------------------------------------------------------------------
module voice_sequencer
  import voice_seq_pkg::*;
#(
  parameter int FREQ_BITS  = 16,
  parameter int STEPS      = 16,
  parameter int STEP_BITS  = $clog2(STEPS),
  parameter int TEMPO_BITS = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [STEP_BITS-1:0]           wr_addr,
  input  logic [FREQ_BITS+CTRL_BITS-1:0] wr_data,
  input  logic                           run,
  input  logic [TEMPO_BITS-1:0]          step_period,
  input  logic [STEP_BITS-1:0]           loop_last,
`ifdef VOICE_SEQ_SWING_EN
  input  logic [TEMPO_BITS-3:0]          swing,
`endif
  output logic [FREQ_BITS-1:0]           tone_freq,
  output logic [WAVE_W-1:0]              waveform_enable,
  output logic                           gate,
  output logic [STEP_BITS-1:0]           step_idx,
  output logic                           step_strobe
);

  localparam int ENTRY_BITS = FREQ_BITS + CTRL_BITS;

  logic [ENTRY_BITS-1:0] pattern [STEPS];
  logic [1:0]            state;
  logic                  playing;
  logic                  do_load;
  logic [STEP_BITS-1:0]  load_idx;
  logic [ENTRY_BITS-1:0] load_entry;
  logic                  step_end;
  logic                  gate_end;

  // The load at a step boundary happens on the same edge that ends the
  // previous step, so each step is exactly its length; the LOAD state itself
  // is only visited once after run rises.
  always_comb begin
    playing    = (state == ST_GATE_ON) || (state == ST_GATE_OFF);
    load_idx   = (state == ST_LOAD || step_idx >= loop_last) ? '0
                                                             : step_idx + 1'b1;
    do_load    = run && ((state == ST_LOAD) || (playing && step_end));
    load_entry = pattern[load_idx];
  end

  voice_seq_timer #(
    .TEMPO_BITS (TEMPO_BITS)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .load        (do_load),
    .active      (playing),
    .step_period (step_period),
    .gate_len    (load_entry[FREQ_BITS+GLEN_OFS +: GLEN_W]),
`ifdef VOICE_SEQ_SWING_EN
    .odd_step    (load_idx[0]),
    .swing       (swing),
`endif
    .step_end    (step_end),
    .gate_end    (gate_end)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= ST_IDLE;
      gate            <= 1'b0;
      step_strobe     <= 1'b0;
      step_idx        <= '0;
      tone_freq       <= '0;
      waveform_enable <= '0;
      // NOTE: the pattern is register-based and must read as all rests after
      // reset, so every entry is cleared here rather than left to a RAM.
      for (int i = 0; i < STEPS; i++) pattern[i] <= '0;
    end else begin
      step_strobe <= 1'b0;
      // Reads for a load on this edge see the pre-write entry, so a write to
      // the playing step only shows up on its next load.
      if (wr_en) pattern[wr_addr] <= wr_data;

      if (!run) begin
        // Stop wins over a coincident boundary; idx/freq/waveform hold.
        state <= ST_IDLE;
        gate  <= 1'b0;
      end else if (do_load) begin
        step_idx        <= load_idx;
        tone_freq       <= load_entry[FREQ_BITS-1:0];
        waveform_enable <= load_entry[FREQ_BITS+WAVE_OFS +: WAVE_W];
        gate            <= load_entry[FREQ_BITS+NOTE_OFS];
        step_strobe     <= 1'b1;
        state           <= load_entry[FREQ_BITS+NOTE_OFS] ? ST_GATE_ON
                                                          : ST_GATE_OFF;
      end else begin
        case (state)
          ST_IDLE:    state <= ST_LOAD;
          ST_GATE_ON: if (gate_end) begin
            gate  <= 1'b0;
            state <= ST_GATE_OFF;
          end
          default:    ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_voice_sequencer.sv
// -----------------------------------------------------------------------------
// tb_voice_sequencer
// Scoreboard bench for voice_sequencer. A step-level reference model predicts
// each step load (index, entry fields, length, gated cycles) and queues it; a
// negedge monitor pops one expectation per step_strobe and measures the step.
// -----------------------------------------------------------------------------
module tb_voice_sequencer;

  localparam int FREQ_BITS  = 16;
  localparam int STEPS      = 16;
  localparam int STEP_BITS  = 4;
  localparam int TEMPO_BITS = 16;
  localparam int ENTRY_BITS = FREQ_BITS + 9;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  wr_en = 1'b0;
  logic [STEP_BITS-1:0]  wr_addr = '0;
  logic [ENTRY_BITS-1:0] wr_data = '0;
  logic                  run = 1'b0;
  logic [TEMPO_BITS-1:0] step_period = 16'd4;
  logic [STEP_BITS-1:0]  loop_last = '0;
`ifdef VOICE_SEQ_SWING_EN
  logic [TEMPO_BITS-3:0] swing = '0;
`endif
  logic [FREQ_BITS-1:0]  tone_freq;
  logic [3:0]            waveform_enable;
  logic                  gate;
  logic [STEP_BITS-1:0]  step_idx;
  logic                  step_strobe;

  voice_sequencer #(
    .FREQ_BITS  (FREQ_BITS),
    .STEPS      (STEPS),
    .TEMPO_BITS (TEMPO_BITS)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .run             (run),
    .step_period     (step_period),
    .loop_last       (loop_last),
`ifdef VOICE_SEQ_SWING_EN
    .swing           (swing),
`endif
    .tone_freq       (tone_freq),
    .waveform_enable (waveform_enable),
    .gate            (gate),
    .step_idx        (step_idx),
    .step_strobe     (step_strobe)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int idx;
    int freq;
    int wave;
    int note;
    int len;
    int high;
  } exp_t;

  exp_t                  sb_q[$];
  logic [ENTRY_BITS-1:0] m_pat [STEPS];
  int m_phase = 0;  // 0 stopped, 1 first load on next edge, 2 playing
  int m_left  = 0;  // cycles of the current step still to run
  int m_idx   = 0;
  int m_freq  = 0;
  int m_wave  = 0;

  task automatic model_load(input int i);
    exp_t e;
    logic [ENTRY_BITS-1:0] ent;
    int p, g, gl;
    ent    = m_pat[i];
    p      = (int'(step_period) < 4) ? 4 : int'(step_period);
    gl     = int'(ent[23:20]);
    g      = (p * (gl + 1)) / 16;
    e.idx  = i;
    e.freq = int'(ent[15:0]);
    e.wave = int'(ent[19:16]);
    e.note = int'(ent[24]);
    e.len  = p;
    e.high = (e.note == 0) ? 0 : (g >= p) ? p : (g < 1) ? 1 : g;
    sb_q.push_back(e);
    m_idx  = i;
    m_freq = e.freq;
    m_wave = e.wave;
    m_left = p;
  endtask

  // Applies the rules for one clock edge using the inputs the DUT will sample.
  task automatic model_edge();
    if (!rst) begin
      m_phase = 0;
      m_idx = 0; m_freq = 0; m_wave = 0;
      foreach (m_pat[j]) m_pat[j] = '0;
    end else begin
      if (!run) m_phase = 0;
      else if (m_phase == 0) m_phase = 1;
      else if (m_phase == 1) begin model_load(0); m_phase = 2; end
      else if (m_left == 1)
        model_load((m_idx >= int'(loop_last)) ? 0 : m_idx + 1);
      else m_left--;
      if (wr_en) m_pat[wr_addr] = wr_data;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int addr, input logic [ENTRY_BITS-1:0] data);
    wr_en = 1'b1; wr_addr = STEP_BITS'(addr); wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_freq"},   tone_freq, 0);
    check({tag, "_wave"},   waveform_enable, 0);
    check({tag, "_gate"},   gate, 0);
    check({tag, "_idx"},    step_idx, 0);
    check({tag, "_strobe"}, step_strobe, 0);
  endtask

  // ---------------- monitor ----------------
  bit   mon_en = 0;
  bit   have_cur = 0;
  bit   broken = 0;
  bit   prev_stop = 1;
  int   len_cnt = 0;
  int   high_cnt = 0;
  exp_t cur;

  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stop) begin
        check("stop_gate", gate, 0);
        check("stop_strobe", step_strobe, 0);
      end
      if (step_strobe) begin
        if (have_cur && !broken) begin
          check("step_len", len_cnt, cur.len);
          check("gate_cycles", high_cnt, cur.high);
        end
        check("sb_depth", sb_q.size(), 1);
        if (sb_q.size() != 0) begin
          cur = sb_q.pop_front();
          check("strobe_idx", step_idx, cur.idx);
          check("strobe_freq", tone_freq, cur.freq);
          check("strobe_wave", waveform_enable, cur.wave);
          check("strobe_gate", gate, cur.note);
          have_cur = 1;
        end
        broken   = 0;
        len_cnt  = 1;
        high_cnt = int'(gate);
      end else if (have_cur) begin
        len_cnt++;
        high_cnt += int'(gate);
      end
      if (!run || !rst) broken = 1;
      prev_stop = !run || !rst;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    foreach (m_pat[j]) m_pat[j] = '0;

    // Reset state.
    repeat (3) tick();
    check_zero_outputs("reset");
    rst = 1'b1;
    mon_en = 1;

    // Fill the pattern while stopped: nothing may play.
    for (int i = 0; i < STEPS; i++) write_entry(i, ENTRY_BITS'($urandom));
    repeat (20) tick();
    check_zero_outputs("idle");

    // Directed two-step loop.
    write_entry(0, {1'b1, 4'd7,  4'b0010, 16'h1000});
    write_entry(1, {1'b1, 4'd15, 4'b0100, 16'h2000});
    loop_last = 4'd1; step_period = 16'd100; run = 1'b1;
    repeat (420) tick();

    // Period below the minimum clamps to 4.
    step_period = 16'd2;
    repeat (40) tick();

    // Shrink loop_last while step 3 plays.
    step_period = 16'd6; loop_last = 4'd7;
    for (int i = 2; i < 8; i++) write_entry(i, ENTRY_BITS'($urandom));
    found = 0;
    for (int c = 0; c < 500 && !found; c++) begin
      if (m_phase == 2 && m_idx == 3) found = 1; else tick();
    end
    check("wait_step3", found, 1);
    loop_last = 4'd1;
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      tick();
      if (m_idx != 3) found = 1;
    end
    check("loop_shrink_idx", step_idx, 0);
    repeat (30) tick();

    // Stop on the same edge as a step boundary, then restart.
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (m_phase == 2 && m_left == 1) found = 1; else tick();
    end
    check("wait_boundary", found, 1);
    run = 1'b0;
    tick();
    check("stop_hold_idx", step_idx, m_idx);
    check("stop_hold_freq", tone_freq, m_freq);
    check("stop_hold_wave", waveform_enable, m_wave);
    repeat (5) tick();
    run = 1'b1;
    repeat (3) tick();
    check("restart_idx", step_idx, 0);
    repeat (30) tick();

    // Write to the step that is playing: outputs hold until it reloads.
    loop_last = 4'd0; step_period = 16'd40;
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (m_phase == 2 && m_left == 30 && m_idx == 0) found = 1; else tick();
    end
    check("wait_midstep", found, 1);
    write_entry(0, {1'b0, 4'd3, 4'b1000, 16'hBEEF});
    repeat (3) tick();
    check("live_write_freq", tone_freq, m_freq);
    check("live_write_wave", waveform_enable, m_wave);
    repeat (80) tick();

    // Randomized play with live writes, tempo/loop changes and run toggles.
    for (int c = 0; c < 3000; c++) begin
      wr_en = ($urandom_range(0, 7) == 0);
      wr_addr = ($urandom_range(0, 3) == 0) ? STEP_BITS'(m_idx)
                                            : STEP_BITS'($urandom_range(0, 15));
      wr_data = ENTRY_BITS'($urandom);
      if ($urandom_range(0, 99) == 0)
        step_period = TEMPO_BITS'($urandom_range(0, 24));
      if ($urandom_range(0, 99) == 0)
        loop_last = STEP_BITS'($urandom_range(0, 15));
      if (run) run = ($urandom_range(0, 199) != 0);
      else     run = ($urandom_range(0, 9) == 0);
      tick();
    end
    wr_en = 1'b0;

    // Reset mid-step clears outputs and pattern.
    run = 1'b1; step_period = 16'd20;
    repeat (25) tick();
    rst = 1'b0;
    tick();
    check_zero_outputs("midreset");
    rst = 1'b1;
    repeat (60) tick();

    run = 1'b0;
    repeat (5) tick();
    check("sb_drain", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
